// File: rtl/class_result_fifo_if.sv
// Result-FIFO bus: producer/host side (master) and FIFO side (slave).
// Signal names match the flat port names of the original block.
interface class_result_fifo_if #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_data_valid;
   logic                  i_rd_en;
   logic                  i_clear;
   logic                  i_intr_ack;
   logic [DATA_WIDTH-1:0] o_rd_data;
   logic [TAG_WIDTH-1:0]  o_rd_tag;
   logic                  o_empty;
   logic                  o_full;
   logic [CW-1:0]         o_count;
   logic [15:0]           o_overflow_cnt;
   logic                  o_intr;

   modport master (
      output i_data, i_data_valid, i_rd_en, i_clear, i_intr_ack,
      input  o_rd_data, o_rd_tag, o_empty, o_full, o_count, o_overflow_cnt, o_intr
   );

   modport slave (
      input  i_data, i_data_valid, i_rd_en, i_clear, i_intr_ack,
      output o_rd_data, o_rd_tag, o_empty, o_full, o_count, o_overflow_cnt, o_intr
   );
endinterface

// File: rtl/class_result_fifo.sv
// FWFT FIFO of argmax results stamped with a frame tag; tracks dropped
// results with a saturating counter and raises a level interrupt on store.
module class_result_fifo #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   class_result_fifo_if.slave  bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = TAG_WIDTH + DATA_WIDTH;

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic [15:0]          ovf_q, ovf_d;
   logic                 intr_q, intr_d;
   logic [EW-1:0]        mem_q [DEPTH];
   logic [EW-1:0]        head;

   logic empty, full, rd_acc, wr_acc, drop;

   always_comb begin
      empty  = (count_q == '0);
      full   = (count_q == CW'(DEPTH));
      rd_acc = bus.i_rd_en && !empty;
      // A full FIFO still accepts when the same-cycle pop frees a slot.
      wr_acc = bus.i_data_valid && (!full || rd_acc);
      drop   = bus.i_data_valid && !wr_acc;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      tag_d    = tag_q;
      ovf_d    = ovf_q;
      intr_d   = intr_q;

      if (bus.i_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         tag_d    = '0;
         ovf_d    = '0;
         intr_d   = 1'b0;
      end else begin
         if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
         if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (bus.i_data_valid) tag_d = tag_q + TAG_WIDTH'(1);
         if (drop && ovf_q != '1) ovf_d = ovf_q + 16'd1;
         if (wr_acc)              intr_d = 1'b1;
         else if (bus.i_intr_ack) intr_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tag_q    <= '0;
         ovf_q    <= '0;
         intr_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         tag_q    <= tag_d;
         ovf_q    <= ovf_d;
         intr_q   <= intr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_acc && !bus.i_clear) mem_q[wr_ptr_q] <= {tag_q, bus.i_data};
   end

   // Storage is not reset; the empty mask keeps stale words off the outputs.
   always_comb begin
      head = mem_q[rd_ptr_q];
      bus.o_rd_data      = empty ? '0 : head[DATA_WIDTH-1:0];
      bus.o_rd_tag       = empty ? '0 : head[EW-1:DATA_WIDTH];
      bus.o_empty        = empty;
      bus.o_full         = full;
      bus.o_count        = count_q;
      bus.o_overflow_cnt = ovf_q;
      bus.o_intr         = intr_q;
   end
endmodule

// File: tb/tb_class_result_fifo.sv
// Self-checking bench for class_result_fifo: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_class_result_fifo;
   localparam int DEPTH = 8;
   localparam int DW    = 32;
   localparam int TW    = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   class_result_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

   class_result_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic [TW-1:0] t;
   } ent_t;

   ent_t        mq[$];
   int unsigned m_tag;
   int unsigned m_ovf;
   bit          m_intr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit            v;
      logic [DW-1:0] d;
      bit            rd;
      logic [CW-1:0] exp_cnt;
      logic [DW-1:0] exp_data;
      logic [TW-1:0] exp_tag;
      bit            exp_empty;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_tag  = 0;
      m_ovf  = 0;
      m_intr = 1'b0;
   endtask

   task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit rd,
                             input bit clr, input bit ack);
      bit   rd_ok, acc;
      ent_t e;
      if (clr) begin
         model_reset();
         return;
      end
      rd_ok = rd && (mq.size() != 0);
      if (rd_ok) void'(mq.pop_front());
      acc = v && (mq.size() < DEPTH);
      if (acc) begin
         e.d = d;
         e.t = TW'(m_tag);
         mq.push_back(e);
         m_intr = 1'b1;
      end else if (ack) begin
         m_intr = 1'b0;
      end
      if (v && !acc && m_ovf < 65535) m_ovf++;
      if (v) m_tag = (m_tag + 1) % (1 << TW);
   endtask

   task automatic check_model();
      logic [DW-1:0] hd;
      logic [TW-1:0] ht;
      hd = (mq.size() != 0) ? mq[0].d : '0;
      ht = (mq.size() != 0) ? mq[0].t : '0;
      check("count",    32'(bus.o_count),        32'(mq.size()));
      check("empty",    32'(bus.o_empty),        32'(mq.size() == 0));
      check("full",     32'(bus.o_full),         32'(mq.size() == DEPTH));
      check("rd_data",  32'(bus.o_rd_data),      32'(hd));
      check("rd_tag",   32'(bus.o_rd_tag),       32'(ht));
      check("overflow", 32'(bus.o_overflow_cnt), 32'(m_ovf));
      check("intr",     32'(bus.o_intr),         32'(m_intr));
   endtask

   // Drive inputs, take one rising edge, advance the model, sample 1 ns later.
   task automatic step(input bit v, input logic [DW-1:0] d, input bit rd,
                       input bit clr, input bit ack, input bit chk);
      bus.i_data_valid = v;
      bus.i_data       = d;
      bus.i_rd_en      = rd;
      bus.i_clear      = clr;
      bus.i_intr_ack   = ack;
      @(posedge clk);
      model_edge(v, d, rd, clr, ack);
      #1;
      if (chk) check_model();
   endtask

   task automatic push(input logic [DW-1:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic pop();
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic clear();
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      bus.i_data       = '0;
      bus.i_data_valid = 1'b0;
      bus.i_rd_en      = 1'b0;
      bus.i_clear      = 1'b0;
      bus.i_intr_ack   = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_model();

      // Directed table: three results in, three pops out.
      tbl[0] = '{1'b1, 32'd7, 1'b0, CW'(1), 32'd7, 8'd0, 1'b0};
      tbl[1] = '{1'b1, 32'd2, 1'b0, CW'(2), 32'd7, 8'd0, 1'b0};
      tbl[2] = '{1'b1, 32'd9, 1'b0, CW'(3), 32'd7, 8'd0, 1'b0};
      tbl[3] = '{1'b0, 32'd0, 1'b1, CW'(2), 32'd2, 8'd1, 1'b0};
      tbl[4] = '{1'b0, 32'd0, 1'b1, CW'(1), 32'd9, 8'd2, 1'b0};
      tbl[5] = '{1'b0, 32'd0, 1'b1, CW'(0), 32'd0, 8'd0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].rd, 1'b0, 1'b0, 1'b0);
         check("tbl_count", 32'(bus.o_count),   32'(tbl[i].exp_cnt));
         check("tbl_data",  32'(bus.o_rd_data), tbl[i].exp_data);
         check("tbl_tag",   32'(bus.o_rd_tag),  32'(tbl[i].exp_tag));
         check("tbl_empty", 32'(bus.o_empty),   32'(tbl[i].exp_empty));
      end

      // Overfill by two, drain, tag keeps counting through the drops.
      clear();
      for (int i = 0; i < 10; i++) push(32'(i));
      check("ovf_full",  32'(bus.o_full),         32'd1);
      check("ovf_count", 32'(bus.o_count),        32'd8);
      check("ovf_cnt2",  32'(bus.o_overflow_cnt), 32'd2);
      for (int i = 0; i < 8; i++) begin
         check("drain_tag", 32'(bus.o_rd_tag), 32'(i));
         pop();
      end
      push(32'd5);
      check("tag_after_drop", 32'(bus.o_rd_tag),  32'd10);
      check("data_after_drop", 32'(bus.o_rd_data), 32'd5);

      // Simultaneous read+write when full, then when empty.
      clear();
      for (int i = 0; i < 8; i++) push(32'(100 + i));
      step(1'b1, 32'd200, 1'b1, 1'b0, 1'b0, 1'b1);
      check("full_rw_ovf",   32'(bus.o_overflow_cnt), 32'd0);
      check("full_rw_count", 32'(bus.o_count),        32'd8);
      check("full_rw_head",  32'(bus.o_rd_data),      32'd101);
      for (int i = 0; i < 8; i++) pop();
      step(1'b1, 32'd55, 1'b1, 1'b0, 1'b0, 1'b1);
      check("empty_rw_count", 32'(bus.o_count),   32'd1);
      check("empty_rw_head",  32'(bus.o_rd_data), 32'd55);

      // Interrupt set, ack, set-wins, drop does not set.
      clear();
      push(32'd3);
      check("intr_set", 32'(bus.o_intr), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("intr_ack", 32'(bus.o_intr), 32'd0);
      step(1'b1, 32'd4, 1'b0, 1'b0, 1'b1, 1'b1);
      check("intr_set_wins", 32'(bus.o_intr), 32'd1);
      for (int i = 0; i < 6; i++) push(32'(i));
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      push(32'd77);
      check("intr_drop", 32'(bus.o_intr), 32'd0);

      // Clear beats a same-cycle write.
      clear();
      for (int i = 0; i < 12; i++) push(32'(i));
      for (int i = 0; i < 3; i++) pop();
      check("pre_clr_count", 32'(bus.o_count),        32'd5);
      check("pre_clr_ovf",   32'(bus.o_overflow_cnt), 32'd4);
      step(1'b1, 32'd99, 1'b0, 1'b1, 1'b0, 1'b1);
      check("clr_count", 32'(bus.o_count),        32'd0);
      check("clr_empty", 32'(bus.o_empty),        32'd1);
      check("clr_ovf",   32'(bus.o_overflow_cnt), 32'd0);
      check("clr_intr",  32'(bus.o_intr),         32'd0);
      push(32'd77);
      check("clr_tag0", 32'(bus.o_rd_tag), 32'd0);

      // Asynchronous reset between edges.
      for (int i = 0; i < 9; i++) push(32'(i + 20));
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("async_count", 32'(bus.o_count),        32'd0);
      check("async_empty", 32'(bus.o_empty),        32'd1);
      check("async_data",  32'(bus.o_rd_data),      32'd0);
      check("async_ovf",   32'(bus.o_overflow_cnt), 32'd0);
      check("async_intr",  32'(bus.o_intr),         32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      push(32'd42);
      check("rst_tag0", 32'(bus.o_rd_tag),  32'd0);
      check("rst_data", 32'(bus.o_rd_data), 32'd42);

      // Overflow counter saturation.
      for (int i = 0; i < 7; i++) push(32'(i));
      for (int i = 0; i < 65540; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      check("sat_ovf", 32'(bus.o_overflow_cnt), 32'hFFFF);
      push(32'd1);
      check("sat_hold", 32'(bus.o_overflow_cnt), 32'hFFFF);

      // Randomized traffic against the model.
      clear();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 55), $urandom(), ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 20), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
